// File: rtl/nibble_serializer.sv
// Word-to-nibble serializer: accepts a WORD_W word over valid/ready and emits
// NUM = WORD_W/NIB_W nibbles over a second valid/ready handshake with first/last marks.
module nibble_serializer #(
  parameter int WORD_W    = 16,
  parameter int NIB_W     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NIB_W-1:0]  out_nib,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last
);

  localparam int NUM   = WORD_W / NIB_W;
  localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [WORD_W-1:0] hold, hold_nxt;
  logic [CNT_W-1:0]  sel;
  logic [WORD_W-1:0] shifted;
  logic              at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      hold  <= hold_nxt;
    end
  end

  assign at_last = (count == LAST_IDX);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    hold_nxt  = hold;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_nxt  = in_data;
          count_nxt = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (at_last) begin
            // Final beat frees the holding register, so a new word can load
            // in the same cycle with no bubble.
            in_ready  = 1'b1;
            count_nxt = '0;
            if (in_valid) begin
              hold_nxt = in_data;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  assign sel       = (MSB_FIRST != 0) ? (LAST_IDX - count) : count;
  assign shifted   = hold >> (int'(sel) * NIB_W);
  assign out_valid = (state == SEND);
  assign out_nib   = out_valid ? shifted[NIB_W-1:0] : '0;
  assign out_first = out_valid && (count == '0);
  assign out_last  = out_valid && at_last;

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: MSB-first and LSB-first instances share stimulus;
// a queue-based beat model is compared every cycle, plus literal sequence checks.
module tb_nibble_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic       m_in_ready, m_out_valid, m_out_first, m_out_last;
  logic [3:0] m_out_nib;
  logic       l_in_ready, l_out_valid, l_out_first, l_out_last;
  logic [3:0] l_out_nib;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serializer #(.WORD_W(16), .NIB_W(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .out_nib(m_out_nib), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_first(m_out_first), .out_last(m_out_last)
  );

  nibble_serializer #(.WORD_W(16), .NIB_W(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .out_nib(l_out_nib), .out_valid(l_out_valid),
    .out_ready(out_ready), .out_first(l_out_first), .out_last(l_out_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of pending beats per instance; a word expands into four beats.
  typedef struct packed {
    logic [3:0] nib;
    logic       first;
    logic       last;
  } beat_t;

  beat_t qm[$];
  beat_t ql[$];

  function automatic logic model_ready();
    return (qm.size() == 0) || (qm.size() == 1 && out_ready);
  endfunction

  task automatic push_word(input logic [15:0] w);
    logic [15:0] t;
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      t = w >> (4 * (3 - i));
      b.nib = t[3:0]; b.first = (i == 0); b.last = (i == 3);
      qm.push_back(b);
      t = w >> (4 * i);
      b.nib = t[3:0];
      ql.push_back(b);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qm.delete();
      ql.delete();
    end else begin
      logic rdy;
      rdy = model_ready();
      if (qm.size() > 0 && out_ready) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (in_valid && rdy) push_word(in_data);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_in_ready", m_in_ready, model_ready());
      chk("l_in_ready", l_in_ready, model_ready());
      chk("m_out_valid", m_out_valid, qm.size() > 0);
      chk("l_out_valid", l_out_valid, ql.size() > 0);
      if (qm.size() > 0 && m_out_valid) begin
        chk("m_beat", {m_out_nib, m_out_first, m_out_last}, qm[0]);
      end
      if (ql.size() > 0 && l_out_valid) begin
        chk("l_beat", {l_out_nib, l_out_first, l_out_last}, ql[0]);
      end
    end
  end

  // Log of accepted beats, used for literal sequence checks.
  logic [63:0] log_m, log_l;
  logic [7:0]  first_m, last_m, first_l, last_l;
  int          n_m;

  always @(posedge clk) begin
    if (!reset) begin
      if (m_out_valid && out_ready) begin
        log_m   <= {log_m[59:0], m_out_nib};
        first_m <= {first_m[6:0], m_out_first};
        last_m  <= {last_m[6:0], m_out_last};
        n_m     <= n_m + 1;
      end
      if (l_out_valid && out_ready) begin
        log_l   <= {log_l[59:0], l_out_nib};
        first_l <= {first_l[6:0], l_out_first};
        last_l  <= {last_l[6:0], l_out_last};
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    log_m = '0; log_l = '0; n_m = 0;
    first_m = '0; last_m = '0; first_l = '0; last_l = '0;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    clear_log();
    #2;
    chk("rst_outputs_m", {m_out_valid, m_out_nib, m_out_first, m_out_last}, '0);
    chk("rst_outputs_l", {l_out_valid, l_out_nib, l_out_first, l_out_last}, '0);
    step(2);
    reset = 1'b0;
    step(1);
    chk("idle_in_ready", m_in_ready, 1'b1);

    // Single word, both nibble orders.
    clear_log();
    in_data = 16'hA5C3; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("first_nib_latency", {m_out_valid, m_out_nib}, {1'b1, 4'hA});
    step(5);
    chk("single_msb_seq", log_m, 64'hA5C3);
    chk("single_lsb_seq", log_l, 64'h3C5A);
    chk("single_count", n_m, 4);
    chk("single_first_m", first_m, 8'b0000_1000);
    chk("single_last_m", last_m, 8'b0000_0001);
    chk("single_first_l", first_l, 8'b0000_1000);
    chk("single_last_l", last_l, 8'b0000_0001);
    chk("single_idle_after", m_out_valid, 1'b0);

    // Back-to-back words with in_valid held high.
    clear_log();
    in_data = 16'h1234; in_valid = 1'b1;
    step(1);
    in_data = 16'hABCD;
    step(3);
    chk("b2b_ready_on_last", m_in_ready, 1'b1);
    step(1);
    in_valid = 1'b0;
    step(5);
    chk("b2b_msb_seq", log_m, 64'h1234ABCD);
    chk("b2b_lsb_seq", log_l, 64'h4321DCBA);
    chk("b2b_count", n_m, 8);

    // Backpressure while nibble 8 is presented.
    clear_log();
    in_data = 16'h9876; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("stall_hold", {m_out_valid, m_out_nib, m_in_ready}, {1'b1, 4'h8, 1'b0});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    step(4);
    chk("stall_msb_seq", log_m, 64'h9876);
    chk("stall_lsb_seq", log_l, 64'h6789);
    chk("stall_count", n_m, 4);

    // Reset in the middle of a word.
    clear_log();
    in_data = 16'hFEDC; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(2);
    chk("pre_reset_seq", log_m, 64'hFE);
    reset = 1'b1;
    #1;
    chk("async_reset_m", {m_out_valid, m_out_nib, m_out_first, m_out_last}, '0);
    chk("async_reset_l", {l_out_valid, l_out_nib, l_out_first, l_out_last}, '0);
    step(1);
    reset = 1'b0;
    #1;
    chk("post_reset_state", {m_out_valid, m_in_ready}, 2'b01);
    step(2);
    clear_log();
    in_data = 16'h0001; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(5);
    chk("after_reset_msb_seq", log_m, 64'h0001);
    chk("after_reset_lsb_seq", log_l, 64'h1000);
    chk("after_reset_count", n_m, 4);
    chk("after_reset_first", first_m, 8'b0000_1000);
    chk("after_reset_last", last_m, 8'b0000_0001);

    // A word offered while busy and withdrawn before the last beat is dropped.
    clear_log();
    in_data = 16'h2222; in_valid = 1'b1;
    step(1);
    in_data = 16'h5555;
    step(2);
    in_valid = 1'b0;
    step(6);
    chk("drop_msb_seq", log_m, 64'h2222);
    chk("drop_count", n_m, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
